// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-cathode 7-segment display.
// Shares one BCD decoder across digits; new contents commit only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL        = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    input  logic                      lz_en,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_done
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_active [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;
    logic                    r_load_ready;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic [3:0]              r_bcd;
    logic                    r_frame_done;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic [3:0]              w_digit;
    logic                    w_blank;
    logic                    w_commit;
    logic                    w_xfer;
    logic [NUM_DIGITS-1:0]   w_dig_en_nxt;
    logic [3:0]              w_bcd_nxt;

    assign load_ready = r_load_ready;
    assign dig_en     = r_dig_en;
    assign bcd_out    = r_bcd;
    assign frame_done = r_frame_done;

    // w_zero_from[i]: digit i and every more significant digit hold zero
    always_comb begin
        w_zero_from = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_from[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (r_active[j] != 4'd0) begin
                    w_zero_from[i] = 1'b0;
                end
            end
        end
    end

    // Next state, commit/transfer strobes and next registered outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_idx_nxt    = r_idx;
        w_commit     = 1'b0;
        w_xfer       = load_valid && !r_pending;
        w_dig_en_nxt = '0;
        w_bcd_nxt    = 4'd0;

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == CNT_W'(DWELL - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        w_idx_nxt = '0;
                        w_commit  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are looked up for the slot the FSM is entering
        w_digit = r_active[w_idx_nxt];
        w_blank = (w_digit > 4'd9) ||
                  (lz_en && (w_idx_nxt != '0) && w_zero_from[w_idx_nxt]);
        if ((w_state_nxt == ST_SHOW) && !w_blank) begin
            w_dig_en_nxt = NUM_DIGITS'(1) << w_idx_nxt;
            w_bcd_nxt    = w_digit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_active[i] <= 4'hF;
            end
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_load_ready <= 1'b1;
            r_dig_en     <= '0;
            r_bcd        <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_dig_en     <= w_dig_en_nxt;
            r_bcd        <= w_bcd_nxt;
            r_frame_done <= w_commit;
            if (w_xfer) begin
                r_shadow <= load_data;
            end
            // A load landing on the commit cycle with nothing pending bypasses the shadow
            if (w_commit) begin
                r_pending    <= 1'b0;
                r_load_ready <= 1'b1;
                if (r_pending) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_active[i] <= r_shadow[4*i +: 4];
                    end
                end else if (w_xfer) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_active[i] <= load_data[4*i +: 4];
                    end
                end
            end else if (w_xfer) begin
                r_pending    <= 1'b1;
                r_load_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: expected frames are queued when loads are driven
// and compared cycle by cycle when the display shows them.
module tb_seg7_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned BL    = 1;
    localparam int unsigned SLOT  = DW + BL;
    localparam int unsigned FRAME = ND * SLOT;

    typedef struct packed {
        logic [15:0] data;
        logic        lz;
        logic [15:0] bcd;   // expected bcd_out per digit slot (nibble k = digit k)
        logic [15:0] en;    // expected dig_en per digit slot
    } vec_t;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_data;
    logic          lz_en;
    logic [3:0]    bcd_out;
    logic [ND-1:0] dig_en;
    logic          frame_done;

    int n_checks;
    int n_errors;

    vec_t sb_q[$];
    vec_t vecs[8];
    vec_t blank_rec;
    vec_t prev;
    vec_t cur;
    vec_t vx;
    vec_t vy;
    vec_t vz;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL        (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_done; the number of cycles taken is itself checked
    task automatic wait_frame(input int exp_steps);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < FRAME + 10);
        chk("frame_done spacing", 32'(n), 32'(exp_steps));
    endtask

    // Compare frame cycles t0..t1; caller is at the sample point of cycle t0
    task automatic check_range(input vec_t e, input int t0, input int t1, input bit fd0);
        int         k;
        int         p;
        logic [3:0] x_en;
        logic [3:0] x_bcd;
        logic       x_fd;
        for (int t = t0; t <= t1; t++) begin
            if (t != t0) step();
            k     = t / SLOT;
            p     = t % SLOT;
            x_en  = (p < BL) ? 4'd0 : e.en[4*k +: 4];
            x_bcd = (p < BL) ? 4'd0 : e.bcd[4*k +: 4];
            x_fd  = fd0 && (t == 0);
            chk($sformatf("scan data=%h t=%0d {fd,en,bcd}", e.data, t),
                32'({frame_done, dig_en, bcd_out}), 32'({x_fd, x_en, x_bcd}));
        end
    endtask

    task automatic pop_exp(output vec_t v);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: queue empty when frame appeared");
            v = blank_rec;
        end else begin
            v = sb_q.pop_front();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        blank_rec = '{data: 16'hFFFF, lz: 1'b0, bcd: 16'h0000, en: 16'h0000};
        vecs[0] = '{data: 16'h4321, lz: 1'b0, bcd: 16'h4321, en: 16'h8421};
        vecs[1] = '{data: 16'h0070, lz: 1'b1, bcd: 16'h0070, en: 16'h0021};
        vecs[2] = '{data: 16'h0070, lz: 1'b0, bcd: 16'h0070, en: 16'h8421};
        vecs[3] = '{data: 16'hA5F5, lz: 1'b0, bcd: 16'h0505, en: 16'h0401};
        vecs[4] = '{data: 16'h0000, lz: 1'b1, bcd: 16'h0000, en: 16'h0001};
        vecs[5] = '{data: 16'h9008, lz: 1'b1, bcd: 16'h9008, en: 16'h8421};
        vecs[6] = '{data: 16'h0900, lz: 1'b1, bcd: 16'h0900, en: 16'h0421};
        vecs[7] = '{data: 16'h0C30, lz: 1'b1, bcd: 16'h0030, en: 16'h0021};
        vx = '{data: 16'h8765, lz: 1'b0, bcd: 16'h8765, en: 16'h8421};
        vy = '{data: 16'h2109, lz: 1'b0, bcd: 16'h2109, en: 16'h8421};
        vz = '{data: 16'h3456, lz: 1'b0, bcd: 16'h3456, en: 16'h8421};

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        lz_en      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset {ready,fd,en,bcd}",
            32'({load_ready, frame_done, dig_en, bcd_out}), 32'h200);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty display: all-blank frames, frame_done every FRAME cycles
        check_range(blank_rec, 0, FRAME - 1, 1'b0);
        wait_frame(1);
        check_range(blank_rec, 0, FRAME - 1, 1'b1);
        prev = blank_rec;

        // Table: load mid-frame, old content holds, new content in next frame
        for (int v = 0; v < 8; v++) begin
            wait_frame(1);
            repeat (7) step();
            load_valid = 1'b1;
            load_data  = vecs[v].data;
            step();
            load_valid = 1'b0;
            chk("load_ready after accept", 32'(load_ready), 32'h0);
            sb_q.push_back(vecs[v]);
            check_range(prev, 8, FRAME - 1, 1'b0);
            lz_en = vecs[v].lz;
            wait_frame(1);
            pop_exp(cur);
            check_range(cur, 0, FRAME - 1, 1'b1);
            prev = cur;
        end

        // Back-to-back: Y held while X pending, accepted only after X commits
        wait_frame(1);
        repeat (7) step();
        load_valid = 1'b1;
        load_data  = vx.data;
        step();
        load_data = vy.data;
        chk("ready low with X pending", 32'(load_ready), 32'h0);
        sb_q.push_back(vx);
        check_range(prev, 8, FRAME - 1, 1'b0);
        chk("Y held off before commit", 32'(load_ready), 32'h0);
        lz_en = 1'b0;
        wait_frame(1);
        chk("ready after X commit", 32'(load_ready), 32'h1);
        pop_exp(cur);
        check_range(cur, 0, 0, 1'b1);
        step();
        load_valid = 1'b0;
        sb_q.push_back(vy);
        chk("ready low with Y pending", 32'(load_ready), 32'h0);
        check_range(cur, 1, FRAME - 1, 1'b0);
        wait_frame(1);
        pop_exp(cur);
        check_range(cur, 0, FRAME - 1, 1'b1);

        // Load exactly on the commit cycle with nothing pending: bypass
        load_valid = 1'b1;
        load_data  = vz.data;
        sb_q.push_back(vz);
        step();
        load_valid = 1'b0;
        chk("ready after bypass load", 32'(load_ready), 32'h1);
        pop_exp(cur);
        check_range(cur, 0, FRAME - 1, 1'b1);

        // Reset during digit 2 slot with a load pending
        wait_frame(1);
        check_range(vz, 0, 7, 1'b1);
        load_valid = 1'b1;
        load_data  = 16'h1111;
        step();
        load_valid = 1'b0;
        chk("ready low before reset", 32'(load_ready), 32'h0);
        check_range(vz, 8, 12, 1'b0);
        reset = 1'b1;
        #1;
        chk("async reset {ready,fd,en,bcd}",
            32'({load_ready, frame_done, dig_en, bcd_out}), 32'h200);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ready after reset release", 32'(load_ready), 32'h1);
        check_range(blank_rec, 0, FRAME - 1, 1'b0);
        wait_frame(1);
        check_range(blank_rec, 0, FRAME - 1, 1'b1);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard drain: %0d entries left, need 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
